// File: rtl/score_keeper_if.sv
// ============================================================================
// score_keeper_if
//   Game-event pulses in, score/high-score/status out for score_keeper.
//   Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface score_keeper_if;
  logic        tick;
  logic        start;
  logic        crash;
  logic [31:0] score;
  logic [31:0] high_score;
  logic        running;
  logic        new_high;

  modport master (
    output tick, start, crash,
    input  score, high_score, running, new_high
  );

  modport slave (
    input  tick, start, crash,
    output score, high_score, running, new_high
  );
endinterface

`default_nettype wire

// File: rtl/score_keeper.sv
// ============================================================================
// score_keeper
//   Copter-game score counter with crash freeze, saturation and high score.
//   Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module score_keeper #(
  parameter int TICKS_PER_POINT = 30,
  parameter int MAX_SCORE       = 999
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  score_keeper_if.slave bus
);

  localparam int c_cnt_w = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TICKS_PER_POINT - 1);
  localparam logic [31:0]        c_max      = 32'(MAX_SCORE);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_over = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_cnt_w-1:0] r_tick_cnt;
  logic [c_cnt_w-1:0] w_tick_cnt_nxt;
  logic [31:0]        r_score;
  logic [31:0]        w_score_nxt;
  logic [31:0]        r_high;
  logic [31:0]        w_high_nxt;
  logic               r_new_high;
  logic               w_new_high_nxt;
  logic               r_running;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= c_st_idle;
      r_tick_cnt <= '0;
      r_score    <= '0;
      r_high     <= '0;
      r_new_high <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_score    <= w_score_nxt;
      r_high     <= w_high_nxt;
      r_new_high <= w_new_high_nxt;
      r_running  <= (w_state_nxt == c_st_run);
    end
  end

  // Crash outranks start while running; start outranks crash once over.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (bus.start) w_state_nxt = c_st_run;
      c_st_run:  if (bus.crash) w_state_nxt = c_st_over;
      c_st_over: if (bus.start) w_state_nxt = c_st_run;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_tick_cnt_nxt = r_tick_cnt;
    w_score_nxt    = r_score;
    w_high_nxt     = r_high;
    w_new_high_nxt = r_new_high;
    case (r_state)
      c_st_idle, c_st_over: begin
        if (bus.start) begin
          w_tick_cnt_nxt = '0;
          w_score_nxt    = '0;
          w_new_high_nxt = 1'b0;
        end
      end
      c_st_run: begin
        if (bus.crash) begin
          if (r_score > r_high) begin
            w_high_nxt     = r_score;
            w_new_high_nxt = 1'b1;
          end
        end else if (bus.tick) begin
          // The frame counter keeps wrapping even once the score has saturated.
          if (r_tick_cnt == c_cnt_last) begin
            w_tick_cnt_nxt = '0;
            if (r_score < c_max) w_score_nxt = r_score + 32'd1;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + c_cnt_w'(1);
          end
        end
      end
      default: begin
        w_tick_cnt_nxt = '0;
        w_score_nxt    = '0;
      end
    endcase
  end

  assign bus.score      = r_score;
  assign bus.high_score = r_high;
  assign bus.running    = r_running;
  assign bus.new_high   = r_new_high;

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// ============================================================================
// tb_score_keeper
//   Scenario tasks plus random pulses against a tick-total score model.
//   Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_keeper;

  localparam int TPP  = 30;
  localparam int MAXS = 999;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  score_keeper_if bus ();

  score_keeper #(
    .TICKS_PER_POINT(TPP),
    .MAX_SCORE      (MAXS)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: 0=idle 1=run 2=over; score derived from ticks counted this run.
  int m_st;
  int m_ticks;
  int m_high;
  bit m_new;

  function automatic int m_score();
    int s;
    s = m_ticks / TPP;
    return (s > MAXS) ? MAXS : s;
  endfunction

  task automatic model_reset();
    m_st = 0; m_ticks = 0; m_high = 0; m_new = 1'b0;
  endtask

  task automatic model_update(input bit t, input bit s, input bit c);
    int sc;
    case (m_st)
      1: begin
        if (c) begin
          sc = m_score();
          m_st = 2;
          if (sc > m_high) begin
            m_high = sc;
            m_new  = 1'b1;
          end
        end else if (t) begin
          m_ticks++;
        end
      end
      default: begin
        if (s) begin
          m_st = 1; m_ticks = 0; m_new = 1'b0;
        end
      end
    endcase
  endtask

  task automatic step(input bit t, input bit s, input bit c);
    bus.tick = t; bus.start = s; bus.crash = c;
    @(posedge clk);
    model_update(t, s, c);
    #1;
    bus.tick = 1'b0; bus.start = 1'b0; bus.crash = 1'b0;
  endtask

  task automatic test_reset();
    bus.tick = 1'b0; bus.start = 1'b0; bus.crash = 1'b0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.score, bus.high_score, bus.running, bus.new_high} !== 66'd0) begin
      bad++;
      $display("FAIL reset_state: score=%0d high=%0d run=%0b nh=%0b expected all zero",
               bus.score, bus.high_score, bus.running, bus.new_high);
    end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b1);
    total++;
    if ({bus.score, bus.running} !== 33'd0) begin
      bad++;
      $display("FAIL idle_ignores: score=%0d run=%0b expected 0 0", bus.score, bus.running);
    end
  endtask

  task automatic test_count();
    step(1'b0, 1'b1, 1'b0);
    total++;
    if (bus.running !== 1'b1 || bus.score !== 32'd0 || bus.new_high !== 1'b0) begin
      bad++;
      $display("FAIL start_run: run=%0b score=%0d nh=%0b expected 1 0 0",
               bus.running, bus.score, bus.new_high);
    end
    for (int i = 1; i <= 90; i++) begin
      step(1'b1, 1'b0, 1'b0);
      total++;
      if (bus.score !== 32'(m_score()) || bus.running !== 1'b1) begin
        bad++;
        $display("FAIL count_tick%0d: score=%0d run=%0b expected %0d 1",
                 i, bus.score, bus.running, m_score());
      end
      if (i % TPP == 0) begin
        total++;
        if (bus.score !== 32'(i / TPP)) begin
          bad++;
          $display("FAIL count_step%0d: score=%0d expected %0d", i, bus.score, i / TPP);
        end
      end
    end
  endtask

  task automatic test_crash_high();
    step(1'b0, 1'b0, 1'b1);
    total++;
    if (bus.running !== 1'b0 || bus.high_score !== 32'd3 || bus.new_high !== 1'b1
        || bus.score !== 32'd3) begin
      bad++;
      $display("FAIL crash_high: run=%0b high=%0d nh=%0b score=%0d expected 0 3 1 3",
               bus.running, bus.high_score, bus.new_high, bus.score);
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, (i % 7) == 0);
      total++;
      if (bus.score !== 32'd3 || bus.running !== 1'b0) begin
        bad++;
        $display("FAIL over_frozen: score=%0d run=%0b expected 3 0", bus.score, bus.running);
      end
    end
  endtask

  task automatic test_equal_and_simul();
    step(1'b0, 1'b1, 1'b0);
    repeat (2 * TPP) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    total++;
    if (bus.score !== 32'd2 || bus.high_score !== 32'd3 || bus.new_high !== 1'b0) begin
      bad++;
      $display("FAIL lower_score: score=%0d high=%0d nh=%0b expected 2 3 0",
               bus.score, bus.high_score, bus.new_high);
    end
    step(1'b0, 1'b1, 1'b0);
    repeat (3 * TPP) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    total++;
    if (bus.running !== 1'b0 || bus.score !== 32'd3 || bus.new_high !== 1'b0
        || bus.high_score !== 32'd3) begin
      bad++;
      $display("FAIL equal_simul_run: run=%0b score=%0d nh=%0b high=%0d expected 0 3 0 3",
               bus.running, bus.score, bus.new_high, bus.high_score);
    end
    step(1'b1, 1'b1, 1'b1);
    total++;
    if (bus.running !== 1'b1 || bus.score !== 32'd0) begin
      bad++;
      $display("FAIL simul_over: run=%0b score=%0d expected 1 0", bus.running, bus.score);
    end
  endtask

  task automatic test_saturate();
    int seen_over;
    seen_over = 0;
    for (int i = 0; i < MAXS * TPP + 60; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (bus.score > 32'(MAXS)) seen_over++;
      total++;
      if (bus.score !== 32'(m_score())) begin
        bad++;
        $display("FAIL saturate_tick%0d: score=%0d expected %0d", i, bus.score, m_score());
      end
    end
    total++;
    if (seen_over != 0 || bus.score !== 32'(MAXS)) begin
      bad++;
      $display("FAIL saturate_cap: score=%0d overs=%0d expected %0d 0", bus.score, seen_over, MAXS);
    end
    step(1'b0, 1'b0, 1'b1);
    total++;
    if (bus.high_score !== 32'(MAXS) || bus.new_high !== 1'b1 || bus.running !== 1'b0) begin
      bad++;
      $display("FAIL saturate_high: high=%0d nh=%0b run=%0b expected %0d 1 0",
               bus.high_score, bus.new_high, bus.running, MAXS);
    end
  endtask

  task automatic test_tick_crash();
    step(1'b0, 1'b1, 1'b0);
    repeat (5 * TPP + TPP - 1) step(1'b1, 1'b0, 1'b0);
    total++;
    if (bus.score !== 32'd5) begin
      bad++;
      $display("FAIL pre_tick_crash: score=%0d expected 5", bus.score);
    end
    step(1'b1, 1'b0, 1'b1);
    total++;
    if (bus.score !== 32'd5 || bus.running !== 1'b0 || bus.new_high !== 1'b0) begin
      bad++;
      $display("FAIL tick_crash: score=%0d run=%0b nh=%0b expected 5 0 0",
               bus.score, bus.running, bus.new_high);
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b1, 1'b0);
    repeat (TPP + 15) step(1'b1, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    total++;
    if ({bus.score, bus.high_score, bus.running, bus.new_high} !== 66'd0) begin
      bad++;
      $display("FAIL async_reset: score=%0d high=%0d run=%0b nh=%0b expected all zero",
               bus.score, bus.high_score, bus.running, bus.new_high);
    end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 1'b1, 1'b0);
    repeat (TPP) step(1'b1, 1'b0, 1'b0);
    total++;
    if (bus.score !== 32'd1 || bus.running !== 1'b1 || bus.high_score !== 32'd0) begin
      bad++;
      $display("FAIL after_reset: score=%0d run=%0b high=%0d expected 1 1 0",
               bus.score, bus.running, bus.high_score);
    end
  endtask

  task automatic test_random();
    bit t, s, c;
    for (int i = 0; i < 4000; i++) begin
      t = ($urandom_range(0, 99) < 70);
      s = ($urandom_range(0, 999) < 8);
      c = ($urandom_range(0, 999) < 6);
      step(t, s, c);
      total++;
      if ({bus.score, bus.high_score, bus.running, bus.new_high}
          !== {32'(m_score()), 32'(m_high), (m_st == 1), m_new}) begin
        bad++;
        $display("FAIL random_cyc%0d: score=%0d high=%0d run=%0b nh=%0b expected %0d %0d %0b %0b",
                 i, bus.score, bus.high_score, bus.running, bus.new_high,
                 m_score(), m_high, (m_st == 1), m_new);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_crash_high();
    test_equal_and_simul();
    test_saturate();
    test_tick_crash();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
